// File: rtl/mdr_bin2bcd_seq.sv
// mdr_bin2bcd_seq: sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Sits between the MDR datapath and the 7-segment decoders.
// Optional feature macro: BCD_SIGN_EN -- treat data_i as two's complement, convert the
// magnitude and publish the sign on sign_o. Without it data_i is unsigned and sign_o is 0.
// Reset is synchronous and active-low on rst_n.

module mdr_bin2bcd_seq #(
  parameter int unsigned W_DATA   = 16,
  parameter int unsigned N_DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [W_DATA-1:0]     data_i,
  output logic                  ready_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [4*N_DIGITS-1:0] bcd_o,
  output logic                  sign_o
);

  localparam int unsigned WBcd  = 4;
  localparam int unsigned WScr  = WBcd * N_DIGITS;
  localparam int unsigned CntW  = (W_DATA > 1) ? $clog2(W_DATA) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(W_DATA - 1);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [W_DATA-1:0] shift_q, shift_d;
  logic [WScr-1:0]   scratch_q, scratch_d;
  logic [WScr-1:0]   bcd_q, bcd_d;

  logic [W_DATA-1:0] operand;
  logic [WScr-1:0]   scratch_adj;
  logic [WScr-1:0]   scratch_sh;
  logic [W_DATA-1:0] shift_sh;
  logic              last_iter;

`ifdef BCD_SIGN_EN
  logic sign_lat_q, sign_lat_d;
  logic sign_q, sign_d;

  // Magnitude as W_DATA-bit unsigned, so the most negative value maps to 2^(W_DATA-1).
  always_comb begin
    operand = data_i;
    if (data_i[W_DATA-1]) begin
      operand = ~data_i + {{(W_DATA-1){1'b0}}, 1'b1};
    end
  end
`else
  // Unsigned build: the operand is the input word as-is.
  always_comb begin
    operand = data_i;
  end
`endif

  // Per-digit add-3 on digits >= 5; no carry between digits, so each digit stays <= 12.
  always_comb begin
    scratch_adj = scratch_q;
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      if (scratch_q[WBcd*i +: WBcd] >= 4'd5) begin
        scratch_adj[WBcd*i +: WBcd] = scratch_q[WBcd*i +: WBcd] + 4'd3;
      end
    end
  end

  // One double-dabble step: {scratch, shift} shifted left by one after the adjust.
  always_comb begin
    scratch_sh = {scratch_adj[WScr-2:0], shift_q[W_DATA-1]};
    shift_sh   = {shift_q[W_DATA-2:0], 1'b0};
    last_iter  = (cnt_q == CntLast);
  end

  // Next-state logic for the FSM and the conversion datapath.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    bcd_d     = bcd_q;
`ifdef BCD_SIGN_EN
    sign_lat_d = sign_lat_q;
    sign_d     = sign_q;
`endif
    case (state_q)
      StIdle: begin
        if (start_i) begin
          shift_d   = operand;
          scratch_d = '0;
          cnt_d     = '0;
`ifdef BCD_SIGN_EN
          sign_lat_d = data_i[W_DATA-1];
`endif
          state_d   = StShift;
        end
      end
      StShift: begin
        shift_d   = shift_sh;
        scratch_d = scratch_sh;
        if (last_iter) begin
          // Publish only the completed result; bcd_o never shows partial values.
          bcd_d   = scratch_sh;
`ifdef BCD_SIGN_EN
          sign_d  = sign_lat_q;
`endif
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      shift_q   <= '0;
      scratch_q <= '0;
      bcd_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      bcd_q     <= bcd_d;
    end
  end

`ifdef BCD_SIGN_EN
  // Sign latched at start and published alongside the digits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sign_lat_q <= 1'b0;
      sign_q     <= 1'b0;
    end else begin
      sign_lat_q <= sign_lat_d;
      sign_q     <= sign_d;
    end
  end

  assign sign_o = sign_q;
`else
  assign sign_o = 1'b0;
`endif

  // Status outputs decoded from the state; done_o is the single DONE cycle.
  always_comb begin
    ready_o = (state_q == StIdle);
    busy_o  = (state_q == StShift) || (state_q == StDone);
    done_o  = (state_q == StDone);
    bcd_o   = bcd_q;
  end

endmodule
